workmem_arbiter: RTL

WORKMEM_ARBITER -- requirements
Module: workmem_arbiter

---
 rtl/workmem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/workmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous work memory.
// Commands issue on registered outputs one cycle after sampling; read data returns one cycle later.
module workmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [7:0]    conflicts
);

  typedef enum logic {IDLE, RD_PEND} trk_e;

  trk_e          trk_q, trk_d;
  logic          owner_q, owner_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          last_q, last_d;
  logic [7:0]    conflicts_q, conflicts_d;

  logic elig0, elig1, win1, grant;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Arbitration: a requester whose grant is showing this cycle sits out one edge.
  always_comb begin
    elig0       = req0 & ~gnt0_q;
    elig1       = req1 & ~gnt1_q;
    grant       = elig0 | elig1;
    win1        = elig1 & (~elig0 | ~last_q);
    gnt0_d      = grant & ~win1;
    gnt1_d      = grant & win1;
    mem_en_d    = grant;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    last_d      = last_q;
    conflicts_d = conflicts_q;
    if (grant) begin
      last_d      = win1;
      mem_we_d    = win1 ? we1 : we0;
      mem_addr_d  = win1 ? addr1 : addr0;
      mem_wdata_d = win1 ? wdata1 : wdata0;
    end
    if (elig0 && elig1) conflicts_d = sat_inc(conflicts_q);
  end

  // Read tracker: remembers who owns the read being issued this cycle.
  always_comb begin
    trk_d   = IDLE;
    owner_d = owner_q;
    rvalid0 = 1'b0;
    rvalid1 = 1'b0;
    if (mem_en_q && !mem_we_q) begin
      trk_d   = RD_PEND;
      owner_d = gnt1_q;
    end
    if (trk_q == RD_PEND) begin
      rvalid0 = ~owner_q;
      rvalid1 = owner_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_q       <= IDLE;
      owner_q     <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      last_q      <= 1'b1;
      conflicts_q <= 8'd0;
    end else begin
      trk_q       <= trk_d;
      owner_q     <= owner_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      last_q      <= last_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign conflicts = conflicts_q;
  assign rdata     = (trk_q == RD_PEND) ? mem_rdata : '0;

endmodule
